// File: rtl/onehot_seq_decoder.sv
// Binary-to-one-hot position sequencer: steps a one-hot position vector toward a
// binary target. Define ONEHOT_SEQ_SHORTEST_PATH_EN to allow moving down when that is shorter.
module onehot_seq_decoder #(
  parameter int WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  T_VALID,
  input  logic [WIDTH-1:0]      T_CODE,
  output logic                  T_READY,
  input  logic                  ABORT,
  output logic [0:2**WIDTH-1]   Q,
  output logic [WIDTH-1:0]      C,
  output logic                  DONE,
  output logic                  WRAP
);

  localparam int N = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  typedef enum logic {
    IDLE,
    MOVE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] tgt, tgt_next;
  logic [WIDTH-1:0] pos_next;
  logic [0:N-1]     q_next;
  logic             done_next, wrap_next;
  logic [0:N-1]     q_up;

  // Q[0] is the leftmost bit, so rotating right moves the hot bit to the next position.
  assign q_up = {Q[N-1], Q[0:N-2]};

`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
  logic             dir_down, dir_down_next;
  logic [WIDTH-1:0] up_dist, dn_dist;
  logic [0:N-1]     q_dn;

  assign q_dn    = {Q[1:N-1], Q[0]};
  assign up_dist = T_CODE - C;
  assign dn_dist = C - T_CODE;
`endif

  assign T_READY = (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    tgt_next   = tgt;
    pos_next   = C;
    q_next     = Q;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
    dir_down_next = dir_down;
`endif
    unique case (state)
      IDLE: begin
        if (T_VALID) begin
          tgt_next = T_CODE;
          if (T_CODE == C) begin
            done_next = 1'b1;
          end else begin
            state_next = MOVE;
`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
            // Ties go up; the direction stays fixed until the move ends.
            dir_down_next = (dn_dist < up_dist);
`endif
          end
        end
      end
      MOVE: begin
        if (ABORT) begin
          state_next = IDLE;
        end else begin
`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
          if (dir_down) begin
            pos_next  = C - WIDTH'(1);
            q_next    = q_dn;
            wrap_next = (C == '0);
          end else begin
            pos_next  = C + WIDTH'(1);
            q_next    = q_up;
            wrap_next = (C == LAST);
          end
`else
          pos_next  = C + WIDTH'(1);
          q_next    = q_up;
          wrap_next = (C == LAST);
`endif
          if (pos_next == tgt) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from
  // the same pre-edge values; Q and C therefore can never be skewed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      tgt   <= '0;
      C     <= '0;
      Q     <= {1'b1, {(N-1){1'b0}}};
      DONE  <= 1'b0;
      WRAP  <= 1'b0;
`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
      dir_down <= 1'b0;
`endif
    end else begin
      state <= state_next;
      tgt   <= tgt_next;
      C     <= pos_next;
      Q     <= q_next;
      DONE  <= done_next;
      WRAP  <= wrap_next;
`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
      dir_down <= dir_down_next;
`endif
    end
  end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Directed self-checking bench for onehot_seq_decoder (WIDTH=4); expectations follow
// ONEHOT_SEQ_SHORTEST_PATH_EN when it is defined.
module tb_onehot_seq_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        T_VALID = 1'b0;
  logic [3:0]  T_CODE = '0;
  logic        T_READY;
  logic        ABORT = 1'b0;
  logic [0:15] Q;
  logic [3:0]  C;
  logic        DONE;
  logic        WRAP;

  int checks = 0;
  int errors = 0;
  int mpos   = 0;

`ifdef ONEHOT_SEQ_SHORTEST_PATH_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif

  onehot_seq_decoder #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .T_VALID(T_VALID), .T_CODE(T_CODE), .T_READY(T_READY),
    .ABORT(ABORT), .Q(Q), .C(C), .DONE(DONE), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_q(input int p);
    logic [15:0] v;
    v = 16'h8000 >> p;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_pos(input string tag, input int p);
    check({tag, ".C"}, 32'(C), 32'(p));
    check({tag, ".Q"}, 32'(Q), 32'(exp_q(p)));
  endtask

  task automatic accept(input int code);
    T_VALID = 1'b1;
    T_CODE  = 4'(code);
    step();
    T_VALID = 1'b0;
    T_CODE  = ~4'(code);
  endtask

  // Reference move: accepts code from the model position and checks every cycle.
  task automatic move(input string tag, input int code);
    int  up, dn, d, prev;
    bit  down;
    up   = (code - mpos) & 15;
    dn   = (mpos - code) & 15;
    down = SP && (dn < up);
    d    = down ? dn : up;
    accept(code);
    if (d == 0) begin
      check({tag, ".same_done"}, 32'(DONE), 32'd1);
      check({tag, ".same_ready"}, 32'(T_READY), 32'd1);
      check_pos({tag, ".same"}, mpos);
    end else begin
      check({tag, ".acc_ready"}, 32'(T_READY), 32'd0);
      check({tag, ".acc_done"}, 32'(DONE), 32'd0);
      for (int i = 1; i <= d; i++) begin
        step();
        prev = mpos;
        mpos = down ? ((mpos - 1) & 15) : ((mpos + 1) & 15);
        check_pos({tag, ".walk"}, mpos);
        check({tag, ".wrap"}, 32'(WRAP), 32'(down ? (prev == 0) : (prev == 15)));
        check({tag, ".done"}, 32'(DONE), 32'(i == d));
        check({tag, ".ready"}, 32'(T_READY), 32'(i == d));
      end
    end
    step();
    check({tag, ".done_end"}, 32'(DONE), 32'd0);
    check({tag, ".wrap_end"}, 32'(WRAP), 32'd0);
  endtask

  initial begin
    int stop_pos, n;
    int sp_seq [4] = '{1, 0, 15, 14};

    // 1. Asynchronous reset, then idle.
    #2 RST = 1'b1;
    #1;
    check_pos("rst_async", 0);
    check("rst_ready", 32'(T_READY), 32'd1);
    step();
    step();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_Q", 32'(Q), 32'h8000);
      check("idle_C", 32'(C), 32'd0);
      check("idle_ready", 32'(T_READY), 32'd1);
      check("idle_done", 32'(DONE), 32'd0);
      check("idle_wrap", 32'(WRAP), 32'd0);
    end

    // 2. Basic move 0 -> 5 (up in both modes).
    accept(5);
    check("mv5_ready0", 32'(T_READY), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_pos("mv5", i);
      check("mv5_done", 32'(DONE), 32'(i == 5));
      check("mv5_ready", 32'(T_READY), 32'(i == 5));
    end
    step();
    check("mv5_done_once", 32'(DONE), 32'd0);
    mpos = 5;

    // 3. Reach 14, then 14 -> 1 wraps through 15 -> 0, then the same target again.
    move("to14", 14);
    accept(1);
    step();
    check_pos("wr_e1", 15);
    check("wr_e1_wrap", 32'(WRAP), 32'd0);
    step();
    check_pos("wr_e2", 0);
    check("wr_e2_wrap", 32'(WRAP), 32'd1);
    check("wr_e2_done", 32'(DONE), 32'd0);
    step();
    check_pos("wr_e3", 1);
    check("wr_e3_wrap", 32'(WRAP), 32'd0);
    check("wr_e3_done", 32'(DONE), 32'd1);
    mpos = 1;
    step();
    move("same1", 1);

    // 4. Abort from 0 toward 9 before the 4th move edge.
    RST = 1'b1;
    step();
    RST = 1'b0;
    mpos = 0;
    stop_pos = SP ? 13 : 3;
    accept(9);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_pos("ab_walk", SP ? (16 - i) : i);
      check("ab_wrap", 32'(WRAP), 32'(SP && i == 1));
      check("ab_done", 32'(DONE), 32'd0);
    end
    ABORT = 1'b1;
    step();
    check_pos("ab_stop", stop_pos);
    check("ab_stop_done", 32'(DONE), 32'd0);
    check("ab_stop_wrap", 32'(WRAP), 32'd0);
    check("ab_stop_ready", 32'(T_READY), 32'd1);
    accept(stop_pos);
    check("ab_same_done", 32'(DONE), 32'd1);
    ABORT = 1'b0;
    step();
    check("ab_same_done_once", 32'(DONE), 32'd0);
    mpos = stop_pos;

    // Abort on the edge that would have reached the target.
    accept((mpos + 1) & 15);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check_pos("abwin", mpos);
    check("abwin_done", 32'(DONE), 32'd0);
    check("abwin_ready", 32'(T_READY), 32'd1);
    step();
    check("abwin_done_late", 32'(DONE), 32'd0);

    // 5. Asynchronous reset in the middle of a move toward 12.
    move("to0", 0);
    accept(12);
    step();
    step();
    check("mid_moving", 32'(T_READY), 32'd0);
    #3 RST = 1'b1;
    #1;
    check_pos("mid_rst", 0);
    check("mid_rst_ready", 32'(T_READY), 32'd1);
    step();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_pos("post_rst", 0);
      check("post_rst_done", 32'(DONE), 32'd0);
    end
    mpos = 0;

    // 6. From 2 toward 14: shortest path goes down 4 edges, otherwise up 12 edges.
    move("to2", 2);
    n = SP ? 4 : 12;
    accept(14);
    for (int i = 1; i <= n; i++) begin
      step();
      check_pos("p6", SP ? sp_seq[i-1] : (2 + i));
      check("p6_wrap", 32'(WRAP), 32'(SP && i == 3));
      check("p6_done", 32'(DONE), 32'(i == n));
    end
    step();
    check("p6_done_once", 32'(DONE), 32'd0);
    check_pos("p6_hold", 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
